// File: rtl/line_edit_pkg.sv
// line_edit_pkg: shared state encoding and ASCII constants for the line editor.
package line_edit_pkg;
  typedef enum logic {EDIT, FLUSH} state_t;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;
endpackage

// File: rtl/line_edit_ctrl_if.sv
// line_edit_ctrl_if: valid/ready byte stream carrying the committed line.
interface line_edit_ctrl_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  modport master(output out_valid, out_data, out_last, input out_ready);
  modport slave(input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/line_stream_out.sv
// line_stream_out: walks the line buffer on go, emits len bytes then a CR marked last, pulses done.
module line_stream_out
  import line_edit_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [PW-1:0]   len,
  input  logic [7:0]      rd_byte,
  output logic [PW-1:0]   rd_idx,
  output logic            done,
  line_edit_ctrl_if.master so
);
  logic [PW-1:0] rd_q, rd_d;
  logic          valid_q, valid_d, last_q, last_d, hs, load;
  logic [7:0]    data_q, data_d;
  always_comb begin
    hs      = valid_q && so.out_ready;
    done    = hs && last_q;
    load    = go || (hs && !last_q);
    rd_idx  = go ? '0 : rd_q + 1'b1;
    rd_d    = load ? rd_idx : rd_q;
    valid_d = go || (valid_q && !done);
    last_d  = load ? rd_idx == len : last_q && !done;
    data_d  = load ? (rd_idx == len ? ASCII_CR : rd_byte) : done ? '0 : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end
  assign so.out_valid = valid_q;
  assign so.out_data  = data_q;
  assign so.out_last  = last_q;
endmodule

// File: rtl/line_edit_ctrl.sv
// line_edit_ctrl: cursor-addressed line editor; Enter streams the line out and clears it.
module line_edit_ctrl
  import line_edit_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  input  logic             left_cursor,
  input  logic             right_cursor,
  input  logic             Delete,
  input  logic             Enter,
  output logic [PW-1:0]    cursor_pos,
  output logic [PW-1:0]    line_len,
  output logic             busy,
  output logic             overflow,
  line_edit_ctrl_if.master so
);
  localparam int AW = $clog2(DEPTH);
  state_t        state_q, state_d;
  logic [PW-1:0] cursor_q, cursor_d, len_q, len_d, rd_idx;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [7:0]    rd_byte;
  logic          overflow_q, overflow_d;
  logic          edit, go, del_ev, left_ev, right_ev, char_ev, full, ins, rm, done;
  always_comb begin
    edit       = state_q == EDIT;
    go         = edit && Enter;
    del_ev     = edit && !Enter && Delete;
    left_ev    = edit && !Enter && !Delete && left_cursor;
    right_ev   = edit && !Enter && !Delete && !left_cursor && right_cursor;
    char_ev    = edit && !Enter && !Delete && !left_cursor && !right_cursor && char_valid &&
                 char_data >= ASCII_MIN && char_data <= ASCII_MAX;
    full       = len_q == PW'(DEPTH);
    ins        = char_ev && !full;
    rm         = del_ev && cursor_q < len_q;
    state_d    = done ? EDIT : go ? FLUSH : state_q;
    cursor_d   = done ? '0 :
                 left_ev && cursor_q != '0 ? cursor_q - 1'b1 :
                 (right_ev && cursor_q != len_q) || ins ? cursor_q + 1'b1 : cursor_q;
    len_d      = done ? '0 : rm ? len_q - 1'b1 : ins ? len_q + 1'b1 : len_q;
    overflow_d = char_ev && full;
    // insert opens a gap at the cursor; delete closes the slot under it
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = ins && PW'(i) == cursor_q ? char_data :
                 ins && PW'(i) > cursor_q ? mem_q[i == 0 ? 0 : i - 1] :
                 rm && PW'(i) >= cursor_q ? mem_q[i == DEPTH - 1 ? i : i + 1] : mem_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EDIT;
      cursor_q   <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rd_byte    = rd_idx < PW'(DEPTH) ? mem_q[rd_idx[AW-1:0]] : '0;
  assign cursor_pos = cursor_q;
  assign line_len   = len_q;
  assign busy       = state_q == FLUSH;
  assign overflow   = overflow_q;
  line_stream_out #(.DEPTH(DEPTH)) u_stream (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .len    (len_q),
    .rd_byte(rd_byte),
    .rd_idx (rd_idx),
    .done   (done),
    .so     (so)
  );
endmodule

// File: tb/tb_line_edit_ctrl.sv
// tb_line_edit_ctrl: queue-based line model checked every cycle, plus literal stream checks.
module tb_line_edit_ctrl;
  localparam int DEPTH = 32;
  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [4:0] E = 5'b10000, D = 5'b01000, L = 5'b00100, R = 5'b00010, C = 5'b00001;
  logic clk = 0, rst = 1, char_valid = 0, left_cursor = 0, right_cursor = 0, del = 0, enter = 0;
  logic [7:0] char_data = 0;
  logic [PW-1:0] cursor_pos, line_len;
  logic busy, overflow, chk_on = 0, toggle = 0;
  line_edit_ctrl_if so();
  line_edit_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .left_cursor(left_cursor), .right_cursor(right_cursor), .Delete(del), .Enter(enter),
    .cursor_pos(cursor_pos), .line_len(line_len), .busy(busy), .overflow(overflow), .so(so)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  byte unsigned m_line[$], cap[$];
  int m_cur = 0, m_idx = 0;
  bit m_busy = 0, m_ovf = 0;
  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", n, act, act, exp, exp, $time);
    end
  endtask
  // model: the line is a byte queue, flush is an index into line+CR
  always @(posedge clk) begin
    if (so.out_valid && so.out_ready) cap.push_back(so.out_data);
    chk_on = 1;
    m_ovf = 0;
    if (rst) begin
      m_line.delete(); m_cur = 0; m_busy = 0; m_idx = 0;
    end else if (m_busy) begin
      if (so.out_ready) begin
        if (m_idx == m_line.size()) begin m_busy = 0; m_line.delete(); m_cur = 0; end
        else m_idx++;
      end
    end else if (enter) begin
      m_busy = 1; m_idx = 0;
    end else if (del) begin
      if (m_cur < m_line.size()) m_line.delete(m_cur);
    end else if (left_cursor) begin
      if (m_cur > 0) m_cur--;
    end else if (right_cursor) begin
      if (m_cur < m_line.size()) m_cur++;
    end else if (char_valid && char_data >= 8'h20 && char_data <= 8'h7E) begin
      if (m_line.size() < DEPTH) begin m_line.insert(m_cur, char_data); m_cur++; end
      else m_ovf = 1;
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("cursor_pos", int'(cursor_pos), m_cur);
    chk("line_len", int'(line_len), m_line.size());
    chk("busy", int'(busy), int'(m_busy));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("out_valid", int'(so.out_valid), int'(m_busy));
    if (m_busy) begin
      chk("out_data", int'(so.out_data), m_idx < m_line.size() ? int'(m_line[m_idx]) : 'h0D);
      chk("out_last", int'(so.out_last), int'(m_idx == m_line.size()));
    end
  end
  initial forever begin
    @(negedge clk); #1;
    if (toggle) so.out_ready = ~so.out_ready;
  end
  task automatic drive(input logic [4:0] ev, input byte unsigned c);
    @(negedge clk); #1;
    {enter, del, left_cursor, right_cursor, char_valid} = ev;
    char_data = c;
    @(negedge clk); #1;
    {enter, del, left_cursor, right_cursor, char_valid} = '0;
  endtask
  task automatic type_str(input string s);
    foreach (s[i]) drive(C, s[i]);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    chk("wait_idle_busy", int'(busy), 0);
  endtask
  task automatic chk_cap(input string n, input byte unsigned e[$]);
    chk({n, "_count"}, cap.size(), e.size());
    foreach (e[i]) chk(n, i < cap.size() ? int'(cap[i]) : -1, int'(e[i]));
    cap.delete();
  endtask
  initial begin
    byte unsigned exp[$];
    so.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_cursor", int'(cursor_pos), 0);
    chk("rst_len", int'(line_len), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(so.out_valid), 0);
    chk("rst_out_data", int'(so.out_data), 0);
    chk("rst_out_last", int'(so.out_last), 0);
    #1 rst = 0;
    type_str("ABC");
    chk("t1_len", int'(line_len), 3);
    chk("t1_cursor", int'(cursor_pos), 3);
    drive(E, 0);
    chk("t1_first_valid", int'(so.out_valid), 1);
    wait_idle();
    chk_cap("t1_stream", '{8'h41, 8'h42, 8'h43, 8'h0D});
    chk("t1_len_after", int'(line_len), 0);
    type_str("ABC");
    drive(L, 0); drive(L, 0);
    drive(C, "X");
    chk("t2_cursor", int'(cursor_pos), 2);
    chk("t2_len", int'(line_len), 4);
    drive(D, 0);
    chk("t2_del_cursor", int'(cursor_pos), 2);
    chk("t2_del_len", int'(line_len), 3);
    drive(E, 0);
    wait_idle();
    chk_cap("t2_stream", '{8'h41, 8'h58, 8'h43, 8'h0D});
    drive(C, "Q");
    repeat (5) drive(L, 0);
    chk("t3_left_clamp", int'(cursor_pos), 0);
    drive(R, 0); drive(R, 0);
    chk("t3_right_clamp", int'(cursor_pos), 1);
    drive(D, 0);
    drive(C, 8'h07);
    chk("t3_noop_len", int'(line_len), 1);
    drive(E, 0);
    wait_idle();
    chk_cap("t3_stream", '{8'h51, 8'h0D});
    exp.delete();
    for (int i = 0; i < DEPTH; i++) begin
      drive(C, 8'(8'h61 + i % 26));
      exp.push_back(8'(8'h61 + i % 26));
    end
    exp.push_back(8'h0D);
    chk("t4_full_len", int'(line_len), DEPTH);
    drive(C, "z");
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_len_held", int'(line_len), DEPTH);
    @(negedge clk);
    chk("t4_overflow_drop", int'(overflow), 0);
    toggle = 1;
    drive(E, 0);
    drive(C, "Z"); drive(L, 0); drive(D, 0); drive(E, 0);
    wait_idle();
    toggle = 0;
    so.out_ready = 1;
    chk_cap("t5_stream", exp);
    drive(E, 0);
    wait_idle();
    chk_cap("t5_empty", '{8'h0D});
    type_str("HI");
    drive(E | L, 0);
    chk("t6_busy", int'(busy), 1);
    chk("t6_cursor_kept", int'(cursor_pos), 2);
    wait_idle();
    chk_cap("t6_stream", '{8'h48, 8'h49, 8'h0D});
    type_str("KL");
    so.out_ready = 0;
    drive(E, 0);
    chk("t6_stall_valid", int'(so.out_valid), 1);
    @(negedge clk); #1 rst = 1;
    @(negedge clk);
    chk("t6_rst_valid", int'(so.out_valid), 0);
    chk("t6_rst_len", int'(line_len), 0);
    chk("t6_rst_cursor", int'(cursor_pos), 0);
    chk("t6_rst_busy", int'(busy), 0);
    #1 rst = 0;
    so.out_ready = 1;
    chk("t6_rst_cap", cap.size(), 0);
    type_str("M");
    drive(E, 0);
    wait_idle();
    chk_cap("t6_post_rst", '{8'h4D, 8'h0D});
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
